// File: rtl/phase_error_capture_pkg.sv
// Shared types and helpers for the phase-error capture buffer.
package phase_error_capture_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FILL = 3'd1,
    WAIT = 3'd2,
    POST = 3'd3,
    READ = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    TRIG_IMM  = 2'b00,
    TRIG_MAG  = 2'b01,
    TRIG_SIGN = 2'b10,
    TRIG_RSVD = 2'b11
  } trig_mode_t;

  localparam int unsigned MAG_W = 32;

  // Callers sign-extend first so the most negative sample keeps its full magnitude.
  function automatic logic [MAG_W-1:0] mag_f(input logic signed [MAG_W-1:0] v);
    logic [MAG_W-1:0] r;
    r = v[MAG_W-1] ? -v : v;
    return r;
  endfunction

endpackage

// File: rtl/phase_error_capture_ram.sv
// Single-clock simple dual-port sample store with a registered, enable-held read port.
module capture_ram
  import phase_error_capture_pkg::*;
#(
  parameter int unsigned ERR_W = 8,
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [ERR_W-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [ERR_W-1:0] rdata_o
);

  logic [ERR_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_o <= mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/phase_error_capture.sv
// Triggered capture of the decimated ADPLL phase-error stream, with
// pre-trigger history, min/max tracking and a valid/ready readout port.
module phase_error_capture
  import phase_error_capture_pkg::*;
#(
  parameter int unsigned ERR_W   = 8,
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned AW      = $clog2(DEPTH),
  parameter int unsigned DECIM_W = 16
) (
  input  logic                    fpga_clk_i,
  input  logic                    reset_i,
  input  logic                    sample_en_i,
  input  logic signed [ERR_W-1:0] error_i,
  input  logic                    arm_i,
  input  logic [1:0]              trig_mode_i,
  input  logic [ERR_W-1:0]        thresh_i,
  input  logic [AW-1:0]           pretrig_i,
  input  logic [DECIM_W-1:0]      decim_i,
  output logic [2:0]              state_o,
  output logic                    done_o,
  output logic signed [ERR_W-1:0] rd_data_o,
  output logic                    rd_valid_o,
  input  logic                    rd_ready_i,
  output logic signed [ERR_W-1:0] min_o,
  output logic signed [ERR_W-1:0] max_o
);

  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  state_t                  state_q, state_d;
  trig_mode_t              mode_q, mode_d;
  logic [ERR_W-1:0]        thresh_q, thresh_d;
  logic [AW-1:0]           pretrig_q, pretrig_d;
  logic [DECIM_W-1:0]      decim_q, decim_d;
  logic [DECIM_W-1:0]      dcnt_q, dcnt_d;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]           start_ptr_q, start_ptr_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [CW-1:0]           rd_cnt_q, rd_cnt_d;
  logic [CW-1:0]           hs_cnt_q, hs_cnt_d;
  logic                    first_q, first_d;
  logic                    prev_neg_q, prev_neg_d;
  logic signed [ERR_W-1:0] min_q, min_d;
  logic signed [ERR_W-1:0] max_q, max_d;
  logic signed [ERR_W-1:0] data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    s1_q, s1_d;
  logic                    done_q, done_d;

  logic [CW-1:0]    post_target;
  logic             capturing;
  logic             strobe;
  logic             accept;
  logic [MAG_W-1:0] err_mag;
  logic             trig_hit;
  logic             out_free;
  logic             issue;
  logic             hs;
  logic [AW-1:0]    ram_raddr;
  logic [ERR_W-1:0] ram_rdata;

  assign post_target = DEPTH_C - {1'b0, pretrig_q};
  // Once the post window is full no further writes land, so the oldest kept sample survives.
  assign capturing = (state_q == FILL) || (state_q == WAIT) ||
                     ((state_q == POST) && (cnt_q != post_target));
  assign strobe    = sample_en_i && capturing;
  assign accept    = strobe && (dcnt_q == '0);
  assign err_mag   = mag_f(MAG_W'(error_i));

  always_comb begin
    case (mode_q)
      TRIG_MAG:  trig_hit = err_mag >= MAG_W'(thresh_q);
      TRIG_SIGN: trig_hit = !first_q && prev_neg_q && !error_i[ERR_W-1];
      default:   trig_hit = 1'b1;
    endcase
  end

  // Two-stage read pipe: s1 marks valid RAM output; the RAM read port stalls with it.
  assign out_free  = !valid_q || rd_ready_i;
  assign issue     = (state_q == READ) && (rd_cnt_q != DEPTH_C) && (!s1_q || out_free);
  assign hs        = valid_q && rd_ready_i;
  assign ram_raddr = start_ptr_q + rd_cnt_q[AW-1:0];

  capture_ram #(
    .ERR_W (ERR_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_i   (fpga_clk_i),
    .we_i    (accept),
    .waddr_i (wr_ptr_q),
    .wdata_i (error_i),
    .re_i    (issue),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    thresh_d    = thresh_q;
    pretrig_d   = pretrig_q;
    decim_d     = decim_q;
    dcnt_d      = dcnt_q;
    wr_ptr_d    = wr_ptr_q;
    start_ptr_d = start_ptr_q;
    cnt_d       = cnt_q;
    rd_cnt_d    = rd_cnt_q;
    hs_cnt_d    = hs_cnt_q;
    first_d     = first_q;
    prev_neg_d  = prev_neg_q;
    min_d       = min_q;
    max_d       = max_q;
    data_d      = data_q;
    valid_d     = valid_q;
    s1_d        = s1_q;
    done_d      = 1'b0;

    if (accept) begin
      wr_ptr_d   = wr_ptr_q + AW'(1);
      dcnt_d     = decim_q;
      first_d    = 1'b0;
      prev_neg_d = error_i[ERR_W-1];
      if (first_q) begin
        min_d = error_i;
        max_d = error_i;
      end else begin
        if (error_i < min_q) min_d = error_i;
        if (error_i > max_q) max_d = error_i;
      end
    end else if (strobe) begin
      dcnt_d = dcnt_q - DECIM_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (arm_i) begin
          state_d   = FILL;
          mode_d    = trig_mode_t'(trig_mode_i);
          thresh_d  = thresh_i;
          pretrig_d = pretrig_i;
          decim_d   = decim_i;
          dcnt_d    = '0;
          cnt_d     = '0;
          first_d   = 1'b1;
        end
      end
      FILL: begin
        if (accept) cnt_d = cnt_q + CW'(1);
        if (cnt_q == {1'b0, pretrig_q}) state_d = WAIT;
      end
      WAIT: begin
        if (accept && trig_hit) begin
          start_ptr_d = wr_ptr_q - pretrig_q;
          cnt_d       = CW'(1);
          state_d     = POST;
        end
      end
      POST: begin
        if (accept) cnt_d = cnt_q + CW'(1);
        if (cnt_q == post_target) begin
          state_d  = READ;
          rd_cnt_d = '0;
          hs_cnt_d = '0;
          s1_d     = 1'b0;
        end
      end
      READ: begin
        if (issue) begin
          rd_cnt_d = rd_cnt_q + CW'(1);
          s1_d     = 1'b1;
        end else if (out_free) begin
          s1_d = 1'b0;
        end
        if (out_free) begin
          valid_d = s1_q;
          if (s1_q) data_d = ram_rdata;
        end
        if (hs) begin
          hs_cnt_d = hs_cnt_q + CW'(1);
          if (hs_cnt_q == DEPTH_C - CW'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
            valid_d = 1'b0;
            s1_d    = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge fpga_clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      mode_q      <= TRIG_IMM;
      thresh_q    <= '0;
      pretrig_q   <= '0;
      decim_q     <= '0;
      dcnt_q      <= '0;
      wr_ptr_q    <= '0;
      start_ptr_q <= '0;
      cnt_q       <= '0;
      rd_cnt_q    <= '0;
      hs_cnt_q    <= '0;
      first_q     <= 1'b1;
      prev_neg_q  <= 1'b0;
      min_q       <= '0;
      max_q       <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      s1_q        <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      thresh_q    <= thresh_d;
      pretrig_q   <= pretrig_d;
      decim_q     <= decim_d;
      dcnt_q      <= dcnt_d;
      wr_ptr_q    <= wr_ptr_d;
      start_ptr_q <= start_ptr_d;
      cnt_q       <= cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      hs_cnt_q    <= hs_cnt_d;
      first_q     <= first_d;
      prev_neg_q  <= prev_neg_d;
      min_q       <= min_d;
      max_q       <= max_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      s1_q        <= s1_d;
      done_q      <= done_d;
    end
  end

  assign state_o    = state_q;
  assign done_o     = done_q;
  assign rd_data_o  = data_q;
  assign rd_valid_o = valid_q;
  assign min_o      = min_q;
  assign max_o      = max_q;

endmodule

// File: tb/tb_phase_error_capture.sv
// Randomised and directed bench for phase_error_capture against a sample-list reference model.
module tb_phase_error_capture;

  localparam int unsigned ERR_W   = 8;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned AW      = 4;
  localparam int unsigned DECIM_W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    reset_i;
  logic                    sample_en_i;
  logic signed [ERR_W-1:0] error_i;
  logic                    arm_i;
  logic [1:0]              trig_mode_i;
  logic [ERR_W-1:0]        thresh_i;
  logic [AW-1:0]           pretrig_i;
  logic [DECIM_W-1:0]      decim_i;
  logic [2:0]              state_o;
  logic                    done_o;
  logic signed [ERR_W-1:0] rd_data_o;
  logic                    rd_valid_o;
  logic                    rd_ready_i;
  logic signed [ERR_W-1:0] min_o;
  logic signed [ERR_W-1:0] max_o;

  phase_error_capture #(
    .ERR_W   (ERR_W),
    .DEPTH   (DEPTH),
    .AW      (AW),
    .DECIM_W (DECIM_W)
  ) dut (
    .fpga_clk_i  (clk),
    .reset_i     (reset_i),
    .sample_en_i (sample_en_i),
    .error_i     (error_i),
    .arm_i       (arm_i),
    .trig_mode_i (trig_mode_i),
    .thresh_i    (thresh_i),
    .pretrig_i   (pretrig_i),
    .decim_i     (decim_i),
    .state_o     (state_o),
    .done_o      (done_o),
    .rd_data_o   (rd_data_o),
    .rd_valid_o  (rd_valid_o),
    .rd_ready_i  (rd_ready_i),
    .min_o       (min_o),
    .max_o       (max_o)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int cyc = 0;
  int read_entry_cyc = 0;
  int done_cnt = 0;
  logic [2:0] prev_st = 3'd0;

  int stim[$];
  int acc[$];
  int exp_win[DEPTH];
  int exp_min, exp_max;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (state_o == 3'd4 && prev_st != 3'd4) read_entry_cyc = cyc;
    prev_st = state_o;
    if (done_o) done_cnt++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: keep every (decim+1)-th strobe, skip pretrig for the fill, find the first
  // triggering sample, and the window is the DEPTH consecutive samples starting pretrig before it.
  function automatic bit model(input int mode, input int thresh, input int pretrig, input int decim);
    int trig = -1;
    int last;
    acc.delete();
    foreach (stim[i]) if (i % (decim + 1) == 0) acc.push_back(stim[i]);
    for (int j = pretrig; j < acc.size(); j++) begin
      bit hit;
      case (mode)
        1:       hit = ((acc[j] < 0) ? -acc[j] : acc[j]) >= thresh;
        2:       hit = (j >= 1) && (acc[j-1] < 0) && (acc[j] >= 0);
        default: hit = 1'b1;
      endcase
      if (hit) begin
        trig = j;
        break;
      end
    end
    if (trig < 0) return 1'b0;
    last = trig + DEPTH - pretrig - 1;
    if (last >= acc.size()) return 1'b0;
    for (int k = 0; k < DEPTH; k++) exp_win[k] = acc[trig - pretrig + k];
    exp_min = acc[0];
    exp_max = acc[0];
    for (int k = 1; k <= last; k++) begin
      if (acc[k] < exp_min) exp_min = acc[k];
      if (acc[k] > exp_max) exp_max = acc[k];
    end
    return 1'b1;
  endfunction

  task automatic do_arm(input int mode, input int thresh, input int pretrig, input int decim);
    @(negedge clk);
    trig_mode_i = 2'(mode);
    thresh_i    = 8'(thresh);
    pretrig_i   = 4'(pretrig);
    decim_i     = 16'(decim);
    arm_i       = 1'b1;
    @(negedge clk);
    arm_i = 1'b0;
    chk("armed_state", int'(state_o), 1);
  endtask

  task automatic feed(input int gap_lo, input int gap_hi, input int target, output bit reached);
    foreach (stim[i]) begin
      int g = int'($urandom_range(gap_hi, gap_lo));
      for (int w = 0; w < g && int'(state_o) != target; w++) @(negedge clk);
      if (int'(state_o) == target) break;
      sample_en_i = 1'b1;
      error_i     = 8'(stim[i]);
      @(negedge clk);
      sample_en_i = 1'b0;
    end
    for (int w = 0; w < 20 && int'(state_o) != target; w++) @(negedge clk);
    reached = (int'(state_o) == target);
  endtask

  task automatic readout(input string name, input int ready_mode, input bit arm_in_read);
    int got = 0;
    int cycles = 0;
    int first_v = -1;
    int last_hs = -1;
    int held = 0;
    bit stalled = 1'b0;
    done_cnt = 0;
    while (got < DEPTH && cycles < 500) begin
      bit r;
      case (ready_mode)
        0:       r = 1'b1;
        1:       r = (cycles % 4 == 0) || (cycles % 4 == 3);
        default: r = ($urandom_range(9, 0) < 7);
      endcase
      rd_ready_i = r;
      if (stalled) begin
        chk({name, "_hold_valid"}, int'(rd_valid_o), 1);
        chk({name, "_hold_data"}, int'(rd_data_o), held);
      end
      if (arm_in_read && cycles == 6) chk({name, "_arm_ignored"}, int'(state_o), 4);
      if (rd_valid_o) begin
        if (first_v < 0) first_v = cyc;
        if (r) begin
          chk($sformatf("%s_rd%0d", name, got), int'(rd_data_o), exp_win[got]);
          got++;
          last_hs = cyc;
        end
      end
      stalled = rd_valid_o && !r;
      held    = int'(rd_data_o);
      arm_i   = arm_in_read && (cycles == 5);
      @(negedge clk);
      cycles++;
    end
    arm_i      = 1'b0;
    rd_ready_i = 1'b0;
    chk({name, "_handshakes"}, got, DEPTH);
    chk({name, "_done_hi"}, int'(done_o), 1);
    chk({name, "_valid_lo"}, int'(rd_valid_o), 0);
    chk({name, "_idle"}, int'(state_o), 0);
    @(negedge clk);
    chk({name, "_done_lo"}, int'(done_o), 0);
    chk({name, "_done_pulses"}, done_cnt, 1);
    chk({name, "_latency"}, first_v - read_entry_cyc, 2);
    if (ready_mode == 0) chk({name, "_throughput"}, last_hs - first_v, DEPTH - 1);
    chk({name, "_min"}, int'(min_o), exp_min);
    chk({name, "_max"}, int'(max_o), exp_max);
  endtask

  task automatic run(input string name, input int mode, input int thresh, input int pretrig,
                     input int decim, input int gap_lo, input int gap_hi, input int ready_mode,
                     input bit arm_in_read);
    bit reached;
    if (!model(mode, thresh, pretrig, decim)) begin
      chk({name, "_stimulus_triggers"}, 0, 1);
      return;
    end
    do_arm(mode, thresh, pretrig, decim);
    feed(gap_lo, gap_hi, 4, reached);
    chk({name, "_reach_read"}, int'(reached), 1);
    if (!reached) return;
    readout(name, ready_mode, arm_in_read);
  endtask

  initial begin
    #5ms;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    bit reached;
    reset_i = 1'b1; sample_en_i = 1'b0; error_i = '0; arm_i = 1'b0;
    trig_mode_i = '0; thresh_i = '0; pretrig_i = '0; decim_i = '0; rd_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    reset_i = 1'b0;
    chk("rst_state", int'(state_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_valid", int'(rd_valid_o), 0);
    chk("rst_data", int'(rd_data_o), 0);
    chk("rst_min", int'(min_o), 0);
    chk("rst_max", int'(max_o), 0);

    stim.delete(); for (int i = 0; i < 16; i++) stim.push_back(i);
    run("imm", 0, 0, 0, 0, 3, 3, 0, 1'b0);

    stim.delete(); for (int i = 0; i < 20; i++) stim.push_back(5 * i);
    run("mag", 1, 20, 4, 0, 1, 3, 0, 1'b0);

    stim.delete(); for (int i = 0; i < 64; i++) stim.push_back(i);
    run("decim", 0, 0, 0, 3, 1, 2, 0, 1'b0);

    stim.delete(); for (int i = -30; i <= 40; i++) stim.push_back(i);
    run("sign", 2, 0, 2, 0, 1, 2, 0, 1'b0);

    stim.delete(); for (int i = 0; i < 16; i++) stim.push_back(i);
    run("bp", 0, 0, 0, 0, 3, 3, 1, 1'b1);

    for (int r = 0; r < 6; r++) begin
      int mode, thresh, pretrig, decim, tries;
      tries = 0;
      do begin
        mode    = int'($urandom_range(3, 0));
        thresh  = int'($urandom_range(120, 0));
        pretrig = int'($urandom_range(DEPTH - 1, 0));
        decim   = int'($urandom_range(3, 0));
        stim.delete();
        for (int i = 0; i < 200; i++) stim.push_back(int'($urandom_range(255, 0)) - 128);
        tries++;
      end while (!model(mode, thresh, pretrig, decim) && tries < 20);
      run($sformatf("rnd%0d", r), mode, thresh, pretrig, decim, 1, 3, 2, 1'b0);
    end

    stim.delete();
    stim = '{3, -5, 7, 1, -128, 2, 4, 6};
    do_arm(1, 127, 4, 0);
    feed(1, 2, 3, reached);
    chk("neg_full_scale_trig", int'(state_o), 3);
    chk("post_min", int'(min_o), -128);
    chk("post_max", int'(max_o), 7);
    @(negedge clk);
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    chk("midrst_state", int'(state_o), 0);
    chk("midrst_valid", int'(rd_valid_o), 0);
    chk("midrst_min", int'(min_o), 0);
    chk("midrst_max", int'(max_o), 0);

    stim.delete(); for (int i = 0; i < 40; i++) stim.push_back(i - 20);
    run("recover", 0, 0, 5, 1, 1, 2, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/phase_error_capture.md
Name: phase_error_capture

Overview:
- Triggered capture buffer for the ADPLL signed phase-error stream. It replaces file-based error logging with on-chip capture.
- Decimates error samples, stores them in a circular RAM with a programmable pre-trigger depth, and freezes on a trigger event.
- Then streams the frozen window out over a valid/ready port, for the display/UART path or a bench monitor.
- Also tracks the min/max error over the capture.

Parameters:
ERR_W, 8, width of signed error sample
DEPTH, 64, capture buffer depth; power of two, >= 4
AW, $clog2(DEPTH), buffer address width (derived)
DECIM_W, 16, width of decimation ratio

Ports:
fpga_clk_i  in  1  system clock; one clock domain
reset_i  in  1  synchronous, active-high reset
sample_en_i  in  1  one-cycle strobe, error_i valid (one per reference edge)
error_i  in  ERR_W  signed phase error
arm_i  in  1  pulse; starts a capture when IDLE
trig_mode_i  in  2  00 immediate, 01 magnitude >= threshold, 10 sign change neg->non-neg, 11 reserved (acts as 00)
thresh_i  in  ERR_W  unsigned magnitude threshold
pretrig_i  in  AW  samples kept before the trigger sample
decim_i  in  DECIM_W  accept 1 of every decim_i+1 strobes
state_o  out  3  current FSM state encoding
done_o  out  1  one-cycle pulse after the last readout handshake
rd_data_o  out  ERR_W  signed readout sample
rd_valid_o  out  1  readout sample valid
rd_ready_i  in  1  readout consumer ready
min_o  out  ERR_W  signed minimum of accepted samples
max_o  out  ERR_W  signed maximum of accepted samples

Behaviour:
- Reset (synchronous, reset_i high at a fpga_clk_i edge):
  - State goes to IDLE.
  - All outputs are 0: done_o, rd_valid_o, rd_data_o, min_o, max_o.
  - The write pointer and all counters clear.
  - Reset asserted mid-capture or mid-readout discards the capture; RAM contents are don't-care.
- Arming: arm_i in IDLE registers trig_mode_i, thresh_i, pretrig_i and decim_i, clears the decimation counter, and moves to FILL. arm_i in any other state is ignored.
- Decimation: the first sample_en_i after arm is accepted. Counter reloads decim_i on accept and decrements on each non-accepted strobe; a strobe is accepted when the counter is 0. Only accepted samples are written, update min/max, and are evaluated for trigger.
- Write: each accepted sample goes to RAM[wr_ptr], then wr_ptr increments mod DEPTH (wraps silently).
- Min/max: the first accepted sample after arm loads both. Later samples update them by signed compare through the end of POST. Values are held until the next arm.
- FILL: counts accepted samples. When the count equals pretrig → WAIT. With pretrig=0, FILL → WAIT on the next cycle. No trigger evaluation in FILL.
- WAIT: the trigger is evaluated on each accepted sample, which is still written.
  - Mode 01: |error| >= thresh. Magnitude is computed in ERR_W+1 bits, so -128 gives 128.
  - Mode 10: previous accepted sample < 0 and current >= 0. The previous sample includes samples from FILL; the first sample after arm never triggers.
  - Mode 00/11: the first accepted sample in WAIT triggers.
  - On trigger: start_ptr = trigger address - pretrig (mod DEPTH). The trigger sample counts as post-sample 1 → POST.
- POST: when DEPTH - pretrig post-samples have been written → READ.
- READ:
  - Samples are read from start_ptr, incrementing mod DEPTH; exactly DEPTH samples are emitted in capture order.
  - The synchronous RAM read plus output register gives first rd_valid_o 2 cycles after entering READ.
  - While rd_valid_o && !rd_ready_i, rd_data_o holds. No loss or duplication under any ready pattern.
  - Throughput is 1 sample/cycle with rd_ready_i held high.
  - After the DEPTH-th handshake: rd_valid_o=0, done_o pulses for 1 cycle, state → IDLE.
  - sample_en_i is ignored in READ and IDLE.
- State encoding: IDLE=0, FILL=1, WAIT=2, POST=3, READ=4.

Decomposition:
- Package phase_error_capture_pkg holds:
  - state enum (IDLE, FILL, WAIT, POST, READ);
  - trig_mode enum (TRIG_IMM, TRIG_MAG, TRIG_SIGN);
  - magnitude helper function.
- Sub-module capture_ram: single-clock simple dual-port RAM, ERR_W x DEPTH, registered read. This keeps the RAM inferable.

Test Plan (DEPTH=16, ERR_W=8):
1. Immediate mode, pretrig=0, decim=0, strobe every 4 cycles with error=0..15 → readout 0..15 in order, done_o single pulse, min=0, max=15, state back to 0.
2. Magnitude mode, thresh=20, pretrig=4, errors 0,5,10,... → trigger on 20; readout 0,5,10,15,20,...,75.
3. Decimation: decim=3, immediate, strobe k carries error=k → accepted 0,4,...,60 read out in order.
4. Sign mode, pretrig=2, errors -30..-1 then 0,1,... (wraps buffer in WAIT) → trigger at 0; readout -2,-1,0..13; min=-30.
5. Backpressure: rd_ready_i pattern 1,0,0,1 repeating during test 1 readout → 16 unique samples in order, rd_data_o stable when stalled; arm_i pulsed during READ is ignored.
6. Magnitude mode with thresh=127, error=-128 → triggers. Reset asserted in POST → next cycle state=0, rd_valid_o=0, min_o=max_o=0.
